// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl
// -----------------------------------------------------------------------------
// Shares one single-port, fixed-latency memory between the instruction fetch
// side (I) and the data side (D) of the pipeline. The data side normally wins
// when both sides request together. A starvation counter forces a fetch grant
// after STARVE_MAX consecutive data grants that were made while a fetch was
// waiting.
//
// Handshake (both sides): the requester raises *_req with its address, write
// flag and write data, and holds all of them stable until *_ack. *_ack is a
// one-cycle pulse. On a read, *_rdData is valid in the ack cycle and holds
// until the next completed read on that side. A req sampled during the ack
// cycle is ignored. The next access starts with the following IDLE cycle.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   i_req/i_addr          fetch request and address
//   i_ack/i_rdData        fetch done pulse and fetched word
//   i_stall               i_req & ~i_ack
//   d_req/d_wr/d_addr/d_wrData   data request, write flag, address, write data
//   d_ack/d_rdData        data done pulse and read data
//   d_stall               d_req & ~d_ack
//   mem_en/mem_wr         memory access active and write qualifier
//   mem_addr/mem_wrData   memory address and write data (registered, stable)
//   mem_rdData            memory read data, valid on the last BUSY cycle
//   dbg_state_o           current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Optional build macro MEM_ARB_STATS_EN adds grant statistics:
//   stat_clr              synchronous clear of the three counters
//   stat_iGrants          number of I grants (saturating)
//   stat_dGrants          number of D grants (saturating)
//   stat_starveWins       number of I grants forced by the starvation counter
// -----------------------------------------------------------------------------
module mem_arb_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdData,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wrData,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdData,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrData,
  input  logic [DATA_W-1:0] mem_rdData,
`ifdef MEM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_iGrants,
  output logic [15:0]       stat_dGrants,
  output logic [15:0]       stat_starveWins,
`endif
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_TOP = 4'(STARVE_MAX);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;     // 0 = I side, 1 = D side
  logic [3:0]          lat_q, lat_d;
  logic [3:0]          starve_q, starve_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   i_rd_q, i_rd_d;
  logic [DATA_W-1:0]   d_rd_q, d_rd_d;

  // Grant-cycle qualifiers, also used by the statistics counters.
  logic                grant;
  logic                grant_d_side;
  logic                starve_win;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      lat_q    <= '0;
      starve_q <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_rd_q   <= '0;
      d_rd_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      i_rd_q   <= i_rd_d;
      d_rd_q   <= d_rd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    i_rd_d       = i_rd_q;
    d_rd_d       = d_rd_q;
    grant        = 1'b0;
    grant_d_side = 1'b0;
    starve_win   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant = 1'b1;
          // D wins a tie unless the fetch side has waited out STARVE_MAX grants.
          if (i_req && d_req) begin
            starve_win   = (starve_q == STARVE_TOP);
            grant_d_side = !starve_win;
          end else begin
            grant_d_side = d_req;
          end
          owner_d = grant_d_side;
          lat_d   = LAT_INIT;
          state_d = ST_BUSY;
          if (grant_d_side) begin
            addr_d  = d_addr;
            wr_d    = d_wr;
            wdata_d = d_wrData;
            // Count only grants that made a waiting fetch wait longer.
            if (!i_req)
              starve_d = '0;
            else if (starve_q != STARVE_TOP)
              starve_d = starve_q + 4'd1;
          end else begin
            addr_d   = i_addr;
            wr_d     = 1'b0;
            wdata_d  = '0;
            starve_d = '0;
          end
        end
      end
      ST_BUSY: begin
        if (lat_q == 4'd0) begin
          // Memory data is valid on the last BUSY cycle; writes leave rdData alone.
          if (owner_q) begin
            if (!wr_q) d_rd_d = mem_rdData;
          end else begin
            i_rd_d = mem_rdData;
          end
          state_d = ST_DONE;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_en      = (state_q == ST_BUSY);
  assign mem_wr      = mem_en && wr_q;
  assign mem_addr    = addr_q;
  assign mem_wrData  = wdata_q;
  assign i_ack       = (state_q == ST_DONE) && !owner_q;
  assign d_ack       = (state_q == ST_DONE) &&  owner_q;
  assign i_rdData    = i_rd_q;
  assign d_rdData    = d_rd_q;
  assign i_stall     = i_req && !i_ack;
  assign d_stall     = d_req && !d_ack;
  assign dbg_state_o = state_q;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_i_q, stat_d_q, stat_sw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_i_q  <= '0;
      stat_d_q  <= '0;
      stat_sw_q <= '0;
    end else if (stat_clr) begin
      stat_i_q  <= '0;
      stat_d_q  <= '0;
      stat_sw_q <= '0;
    end else if (grant) begin
      if (grant_d_side) begin
        if (stat_d_q != 16'hFFFF) stat_d_q <= stat_d_q + 16'd1;
      end else begin
        if (stat_i_q != 16'hFFFF) stat_i_q <= stat_i_q + 16'd1;
      end
      if (starve_win && stat_sw_q != 16'hFFFF) stat_sw_q <= stat_sw_q + 16'd1;
    end
  end

  assign stat_iGrants    = stat_i_q;
  assign stat_dGrants    = stat_d_q;
  assign stat_starveWins = stat_sw_q;
`endif

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Testbench for mem_arb_ctrl: directed vectors with hand-computed expectations.
// u_dut uses MEM_LAT=4, STARVE_MAX=3; u_dut1 uses MEM_LAT=1.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_mem_arb_ctrl;

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wrData;
  logic        i_ack, d_ack, i_stall, d_stall, mem_en, mem_wr;
  logic [15:0] i_rdData, d_rdData, mem_addr, mem_wrData, mem_rdData;
  logic [1:0]  dbg_state;

  logic        i_req1;
  logic [15:0] i_addr1;
  logic        i_ack1, d_ack1, i_stall1, d_stall1, mem_en1, mem_wr1;
  logic [15:0] i_rdData1, d_rdData1, mem_addr1, mem_wrData1;
  logic [15:0] mem_rdData1;
  logic [1:0]  dbg_state1;
  logic        zero_b;
  logic [15:0] zero_w;

  logic        stat_clr;
  logic [15:0] stat_iGrants, stat_dGrants, stat_starveWins;
  logic [15:0] stat_iGrants1, stat_dGrants1, stat_starveWins1;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model (read-only lookup table) ----------------
  always_comb begin
    mem_rdData = 16'h0000;
    if (mem_en) begin
      case (mem_addr)
        16'h0010: mem_rdData = 16'hBEEF;
        16'h0040: mem_rdData = 16'h1357;
        16'h0200: mem_rdData = 16'h5A5A;
        default:  mem_rdData = 16'hDEAD;
      endcase
    end
  end
  assign mem_rdData1 = 16'hCAFE;
  assign zero_b = 1'b0;
  assign zero_w = 16'h0000;

  mem_arb_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4), .STARVE_MAX(3)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdData(i_rdData), .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wrData(d_wrData),
    .d_ack(d_ack), .d_rdData(d_rdData), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wrData(mem_wrData),
    .mem_rdData(mem_rdData),
`ifdef MEM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_iGrants(stat_iGrants), .stat_dGrants(stat_dGrants),
    .stat_starveWins(stat_starveWins),
`endif
    .dbg_state_o(dbg_state)
  );

  mem_arb_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_ack(i_ack1), .i_rdData(i_rdData1), .i_stall(i_stall1),
    .d_req(zero_b), .d_wr(zero_b), .d_addr(zero_w), .d_wrData(zero_w),
    .d_ack(d_ack1), .d_rdData(d_rdData1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wrData(mem_wrData1),
    .mem_rdData(mem_rdData1),
`ifdef MEM_ARB_STATS_EN
    .stat_clr(zero_b), .stat_iGrants(stat_iGrants1), .stat_dGrants(stat_dGrants1),
    .stat_starveWins(stat_starveWins1),
`endif
    .dbg_state_o(dbg_state1)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; stat_clr = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wrData = '0;
    i_req1 = 1'b0; i_addr1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_acks", {i_ack, d_ack}, 0);
    check("rst_rddata", {i_rdData, d_rdData}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: single fetch, ack at cycle 5
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin i_req = 1'b1; i_addr = 16'h0010; end
      if (c == 6) i_req = 1'b0;
      #1;
      check("f_mem_en", mem_en, (c >= 1 && c <= 4));
      check("f_i_ack", i_ack, (c == 5));
      check("f_i_stall", i_stall, (c <= 4));
      if (c >= 1 && c <= 4) begin
        check("f_mem_addr", mem_addr, 16'h0010);
        check("f_mem_wr", mem_wr, 0);
      end
      if (c == 3) check("f_state_busy", dbg_state, 1);
      if (c == 5) begin
        check("f_i_rdData", i_rdData, 16'hBEEF);
        check("f_state_done", dbg_state, 2);
      end
    end

    // Test 2: simultaneous requests, D first then I
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
      end
      if (c == 6)  d_req = 1'b0;
      if (c == 12) i_req = 1'b0;
      #1;
      check("s_d_ack", d_ack, (c == 5));
      check("s_i_ack", i_ack, (c == 11));
      check("s_mem_en", mem_en, ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
      check("s_d_stall", d_stall, (c <= 4));
      check("s_i_stall", i_stall, (c <= 10));
      if (c == 2)  check("s_addr_d", mem_addr, 16'h0200);
      if (c == 8)  check("s_addr_i", mem_addr, 16'h0040);
      if (c == 5)  check("s_d_rdData", d_rdData, 16'h5A5A);
      if (c == 11) check("s_i_rdData", i_rdData, 16'h1357);
    end

    // Test 3: starvation, both held; grant order D, D, D, I, D
    for (int c = 0; c <= 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
      end
      if (c == 30) begin i_req = 1'b0; d_req = 1'b0; end
      #1;
      if (c % 6 == 5) begin
        check("v_d_ack", d_ack, (c != 23));
        check("v_i_ack", i_ack, (c == 23));
      end
`ifdef MEM_ARB_STATS_EN
      if (c == 17) check("v_starve_before", stat_starveWins, 0);
      if (c == 19) check("v_starve_wins", stat_starveWins, 1);
      if (c == 30) begin
        check("v_i_grants", stat_iGrants, 3);
        check("v_d_grants", stat_dGrants, 5);
      end
`endif
    end

    // Test 4: data write; d_rdData keeps the last read value
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wrData = 16'h1234;
      end
      if (c == 6) d_req = 1'b0;
      #1;
      check("w_mem_wr", mem_wr, (c >= 1 && c <= 4));
      check("w_d_ack", d_ack, (c == 5));
      if (c >= 1 && c <= 4) begin
        check("w_mem_wrData", mem_wrData, 16'h1234);
        check("w_mem_addr", mem_addr, 16'h0300);
      end
      if (c >= 5) check("w_d_rdData", d_rdData, 16'h5A5A);
    end

    // Test 5: reset during the second BUSY cycle of a write
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      if (c == 0) begin
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wrData = 16'h9999;
      end
      #1;
      if (c >= 1) check("r_busy_en", mem_en, 1);
    end
    rst = 1'b1;
    #1;
    check("r_en_off", mem_en, 0);
    check("r_state_idle", dbg_state, 0);
    check("r_no_ack", d_ack, 0);
    @(negedge clk);
    d_req = 1'b0; d_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      #1;
      check("r_quiet_ack", {i_ack, d_ack}, 0);
      check("r_quiet_en", mem_en, 0);
    end
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 0) begin i_req = 1'b1; i_addr = 16'h0010; end
      if (c == 6) i_req = 1'b0;
      #1;
      check("r_f_i_ack", i_ack, (c == 5));
      check("r_f_mem_en", mem_en, (c >= 1 && c <= 4));
      if (c == 5) check("r_f_i_rdData", i_rdData, 16'hBEEF);
    end

`ifdef MEM_ARB_STATS_EN
    // Statistics: one I grant since the reset, then a synchronous clear
    check("st_i_after_rst", stat_iGrants, 1);
    check("st_d_after_rst", stat_dGrants, 0);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    check("st_clr_i", stat_iGrants, 0);
`endif

    // Test 6: MEM_LAT=1 single fetch on the second instance
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 0) begin i_req1 = 1'b1; i_addr1 = 16'h0022; end
      if (c == 3) i_req1 = 1'b0;
      #1;
      check("l1_mem_en", mem_en1, (c == 1));
      check("l1_i_ack", i_ack1, (c == 2));
      if (c == 1) check("l1_mem_addr", mem_addr1, 16'h0022);
      if (c == 2) check("l1_i_rdData", i_rdData1, 16'hCAFE);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
